regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
Controller in front of the Eka core's 2-read/1-write register file.
- After reset, it sequentially clears x1..x31 through the write port.
- It then arbitrates the single write port between two writeback requesters: wb0 (ALU) and wb1 (load unit).
- It keeps a per-register pending-write scoreboard, so decode can stall on read-after-write hazards.
- Its outputs drive the register file write port directly.

Parameters:
NUM_REGS, 32, architectural register count (x0 hardwired zero)
ADDR_W, 5, register address width
DATA_W, 32, register data width
INIT_CLEAR, 1, 1 = run the clear sequence after reset; 0 = skip it

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
wb0_valid  in  1  ALU writeback request
wb0_ready  out  1  ALU request accepted this cycle
wb0_addr  in  ADDR_W  ALU destination register
wb0_data  in  DATA_W  ALU result
wb1_valid  in  1  load-unit writeback request
wb1_ready  out  1  load-unit request accepted this cycle
wb1_addr  in  ADDR_W  load destination register
wb1_data  in  DATA_W  load data
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  ADDR_W  destination register of the issued instruction
rs1_addr  in  ADDR_W  decode source register 1
rs2_addr  in  ADDR_W  decode source register 2
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
init_done  out  1  clear sequence complete; scheduler in RUN
rf_write_en  out  1  register file write enable
rf_write_addr  out  ADDR_W  register file write address
rf_write_data  out  DATA_W  register file write data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = INIT, cnt = 1, busy[] = 0, last_grant = 1 (wb0 wins the first conflict).
  - rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, init_done = 0.
- Reset mid-operation:
  - Pending handshakes are dropped and the scoreboard is wiped.
  - INIT restarts; no partially registered write is emitted.
- FSM state INIT:
  - wb*_ready = 0; issue_valid is ignored.
  - Each cycle registers rf_write_en = 1, rf_write_addr = cnt, rf_write_data = 0, then cnt++.
  - After cnt = 31 is registered, go to RUN and set init_done = 1.
  - With the first INIT cycle after reset deasserts counted as cycle 1, rf_write_en is high for cycles 2..32 and init_done is high from cycle 33.
  - INIT_CLEAR = 0: go to RUN on the first cycle after reset, with no writes.
- FSM state RUN (terminal until reset). Arbitration is combinational:
  - Only one valid: that requester gets ready = 1.
  - Both valid: grant the requester not in last_grant, then update last_grant (round-robin).
- Accepted request (valid && ready at edge E0):
  - At E0, register rf_write_addr/data.
  - rf_write_en is registered as 1 at E0 unless addr == 0.
  - If addr == 0: the handshake completes, rf_write_en = 0, and the data is discarded.
  - rf_write_en is a single-cycle pulse; it falls at the next edge unless another request is accepted.
- Latency: handshake to register file write is 1 cycle (the register file captures at E1).
- Throughput: 1 write per cycle; the losing requester holds valid/addr/data stable until ready.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the next edge; x0 is never busy.
  - Writes with addr != 0 clear busy[addr] at E1, the edge where the register file captures the data.
  - Set and clear of the same register on the same edge: set wins.
  - Issuing to an already-busy register leaves it busy; the bit is single, not counted.
  - The in-order core guarantees at most one outstanding writer per register.
- Busy outputs: rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], combinational; address 0 always gives 0.

Optional Feature:
Macro: REGFILE_SB_EARLY_CLEAR_EN
- Defined: busy[addr] clears at E0, the handshake edge, for use with a register file that has write-through bypass. Hazard stalls shorten by 1 cycle.
- Undefined: busy clears at E1, as specified in Behaviour.

Decomposition:
- Shared package eka_rf_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS
  - state encoding localparams ST_INIT, ST_RUN
  - grant encoding GRANT_WB0, GRANT_WB1
- One sub-module: rf_scoreboard.
  - Contents: busy vector, set/clear priority, two combinational read ports, and the early-clear macro.
  - The FSM and arbiter stay in the top module.

Test Plan:
- Reset for 2 cycles, then release -> rf_write_en high for exactly 31 cycles, addresses 1..31 in order, data 0; wb0_ready/wb1_ready = 0 throughout; init_done rises in cycle 33.
- After init, wb0 {addr 5, data 0xDEADBEEF} valid alone -> wb0_ready = 1 the same cycle; next cycle rf_write_en = 1, addr 5, data 0xDEADBEEF.
- wb0 {3, 0x11} and wb1 {4, 0x22} valid together for 3 cycles -> grants wb0, wb1, wb0; wb1 held stable until accepted.
- issue_valid, issue_rd = 7; rs1_addr = 7 -> rs1_busy = 1 the next cycle; wb1 {7, 0xA5} accepted at E0 -> rs1_busy falls at E1 (at E0 with REGFILE_SB_EARLY_CLEAR_EN).
- wb0 {0, 0xFFFFFFFF} -> handshake completes, rf_write_en stays 0; issue_rd = 0 -> rs1_busy (rs1_addr = 0) stays 0.
- Assert reset during RUN while busy[9] = 1 and wb0 valid -> no write emitted, busy cleared, INIT restarts at address 1.

Source files
------------

// File: rtl/eka_rf_pkg.sv
// Shared sizes, FSM state encoding and arbitration grant encoding for the
// Eka register file write scheduler.
package eka_rf_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic GRANT_WB0 = 1'b0;
   localparam logic GRANT_WB1 = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with two combinational lookup ports.
// Build option REGFILE_SB_EARLY_CLEAR_EN: clear on the handshake edge instead of the capture edge.
module rf_scoreboard
   import eka_rf_pkg::*;
#(
   parameter int NUM_REGS = eka_rf_pkg::NUM_REGS,
   parameter int ADDR_W   = eka_rf_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              hs_en,
   input  logic [ADDR_W-1:0] hs_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_next;
   logic                clr_en;
   logic [ADDR_W-1:0]   clr_addr;
   logic                unused_clr;

`ifdef REGFILE_SB_EARLY_CLEAR_EN
   assign clr_en     = hs_en;
   assign clr_addr   = hs_addr;
   assign unused_clr = ^{wr_en, wr_addr};
`else
   assign clr_en     = wr_en;
   assign clr_addr   = wr_addr;
   assign unused_clr = ^{hs_en, hs_addr};
`endif

   // Next busy vector: x0 never busy, a same-edge set beats a clear.
   always_comb begin
      busy_next = busy;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i == 0) begin
            busy_next[i] = 1'b0;
         end else if (set_en && (set_addr == ADDR_W'(i))) begin
            busy_next[i] = 1'b1;
         end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
            busy_next[i] = 1'b0;
         end else begin
            busy_next[i] = busy[i];
         end
      end
   end

   // Busy vector register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= {NUM_REGS{1'b0}};
      end else begin
         busy <= busy_next;
      end
   end

   assign rs1_busy = (rs1_addr != {ADDR_W{1'b0}}) && busy[rs1_addr];
   assign rs2_busy = (rs2_addr != {ADDR_W{1'b0}}) && busy[rs2_addr];

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register file write scheduler: clears x1..x31 after reset, then round-robins wb0/wb1 onto the write port.
// Build option REGFILE_SB_EARLY_CLEAR_EN (handled in rf_scoreboard) releases busy bits on the handshake edge.
module regfile_write_scheduler
   import eka_rf_pkg::*;
#(
   parameter int NUM_REGS   = eka_rf_pkg::NUM_REGS,
   parameter int ADDR_W     = eka_rf_pkg::ADDR_W,
   parameter int DATA_W     = eka_rf_pkg::DATA_W,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb0_valid,
   output logic              wb0_ready,
   input  logic [ADDR_W-1:0] wb0_addr,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_valid,
   output logic              wb1_ready,
   input  logic [ADDR_W-1:0] wb1_addr,
   input  logic [DATA_W-1:0] wb1_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              init_done,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data
);

   localparam int              CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic               last_grant;
   logic               last_grant_next;
   logic               we_next;
   logic [ADDR_W-1:0]  waddr_next;
   logic [DATA_W-1:0]  wdata_next;
   logic               init_done_next;
   logic               hs_en;
   logic [ADDR_W-1:0]  hs_addr;
   logic               set_en;

   // Next-state, arbitration and write-port next values.
   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      last_grant_next = last_grant;
      we_next         = 1'b0;
      waddr_next      = rf_write_addr;
      wdata_next      = rf_write_data;
      init_done_next  = init_done;
      wb0_ready       = 1'b0;
      wb1_ready       = 1'b0;
      hs_en           = 1'b0;
      hs_addr         = {ADDR_W{1'b0}};
      set_en          = 1'b0;
      case (state)
         ST_INIT: begin
            // cnt reaching NUM_REGS is one idle cycle after x31 is written.
            if ((INIT_CLEAR == 1'b0) || (cnt == CNT_END)) begin
               state_next     = ST_RUN;
               init_done_next = 1'b1;
            end else begin
               we_next    = 1'b1;
               waddr_next = cnt[ADDR_W-1:0];
               wdata_next = {DATA_W{1'b0}};
               cnt_next   = cnt + CNT_ONE;
            end
         end
         ST_RUN: begin
            wb0_ready = wb0_valid && (!wb1_valid || (last_grant == GRANT_WB1));
            wb1_ready = wb1_valid && (!wb0_valid || (last_grant == GRANT_WB0));
            set_en    = issue_valid && (issue_rd != {ADDR_W{1'b0}});
            // The rotation only advances on a real conflict.
            if (wb0_valid && wb1_valid) begin
               last_grant_next = wb0_ready ? GRANT_WB0 : GRANT_WB1;
            end else begin
               last_grant_next = last_grant;
            end
            if (wb0_ready) begin
               hs_addr    = wb0_addr;
               waddr_next = wb0_addr;
               wdata_next = wb0_data;
            end else if (wb1_ready) begin
               hs_addr    = wb1_addr;
               waddr_next = wb1_addr;
               wdata_next = wb1_data;
            end else begin
               hs_addr    = {ADDR_W{1'b0}};
            end
            hs_en   = (wb0_ready || wb1_ready) && (hs_addr != {ADDR_W{1'b0}});
            we_next = hs_en;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // FSM state, clear counter, arbitration history and registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_INIT;
         cnt           <= CNT_ONE;
         last_grant    <= GRANT_WB1;
         rf_write_en   <= 1'b0;
         rf_write_addr <= {ADDR_W{1'b0}};
         rf_write_data <= {DATA_W{1'b0}};
         init_done     <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         last_grant    <= last_grant_next;
         rf_write_en   <= we_next;
         rf_write_addr <= waddr_next;
         rf_write_data <= wdata_next;
         init_done     <= init_done_next;
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (set_en),
      .set_addr (issue_rd),
      .hs_en    (hs_en),
      .hs_addr  (hs_addr),
      .wr_en    (rf_write_en),
      .wr_addr  (rf_write_addr),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy)
   );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: a cycle-level reference model queues expected
// register file writes and a separate monitor matches them against the write port.
module tb_regfile_write_scheduler;

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb0_valid = 1'b0, wb1_valid = 1'b0, issue_valid = 1'b0;
   logic        wb0_ready, wb1_ready, rs1_busy, rs2_busy, init_done, rf_write_en;
   logic [4:0]  wb0_addr = 5'd0, wb1_addr = 5'd0, issue_rd = 5'd0, rs1_addr = 5'd0, rs2_addr = 5'd0;
   logic [31:0] wb0_data = 32'd0, wb1_data = 32'd0;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   started = 1'b0;
   bit   acc0 = 1'b0, acc1 = 1'b0;
   wr_t  exp_q[$];

   regfile_write_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .wb0_valid     (wb0_valid),
      .wb0_ready     (wb0_ready),
      .wb0_addr      (wb0_addr),
      .wb0_data      (wb0_data),
      .wb1_valid     (wb1_valid),
      .wb1_ready     (wb1_ready),
      .wb1_addr      (wb1_addr),
      .wb1_data      (wb1_data),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .init_done     (init_done),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: k counts cycles since reset release; the scheduler is in RUN from cycle 33,
   // x1..x31 are written in cycles 2..32, and ties alternate starting with wb0.
   initial begin : model
      int          k;
      bit          tie_wb0;
      logic [31:0] mbusy;
      logic [31:0] nb;
      bit          pend_v;
      logic [4:0]  pend_a;
      bit          run, e0, e1, hv;
      logic [4:0]  a;
      logic [31:0] d;
      k = 0; tie_wb0 = 1'b1; mbusy = 32'd0; pend_v = 1'b0; pend_a = 5'd0;
      forever begin
         @(negedge clk);
         if (started) begin
            if (!reset) k = (k < 100) ? k + 1 : k;
            chk1("init_done", init_done, k >= 33);
            chk1("rs1_busy", rs1_busy, (rs1_addr != 5'd0) && mbusy[rs1_addr]);
            chk1("rs2_busy", rs2_busy, (rs2_addr != 5'd0) && mbusy[rs2_addr]);
            if (reset) begin
               k = 0; tie_wb0 = 1'b1; mbusy = 32'd0; pend_v = 1'b0;
               acc0 = 1'b0; acc1 = 1'b0;
            end else begin
               run = (k >= 33);
               if (!run) begin
                  e0 = 1'b0; e1 = 1'b0;
               end else if (wb0_valid && wb1_valid) begin
                  e0 = tie_wb0; e1 = !tie_wb0; tie_wb0 = !tie_wb0;
               end else begin
                  e0 = wb0_valid; e1 = wb1_valid;
               end
               chk1("wb0_ready", wb0_ready, e0);
               chk1("wb1_ready", wb1_ready, e1);
               acc0 = e0; acc1 = e1;
               if (k <= 31) exp_q.push_back('{cyc: cyc + 1, addr: 5'(k), data: 32'd0});
               hv = e0 || e1;
               a  = e0 ? wb0_addr : wb1_addr;
               d  = e0 ? wb0_data : wb1_data;
               if (hv && a != 5'd0) exp_q.push_back('{cyc: cyc + 1, addr: a, data: d});
               nb = mbusy;
               if (pend_v) nb[pend_a] = 1'b0;
`ifdef REGFILE_SB_EARLY_CLEAR_EN
               if (hv && a != 5'd0) nb[a] = 1'b0;
               pend_v = 1'b0;
`else
               pend_v = hv && (a != 5'd0);
               pend_a = a;
`endif
               if (run && issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
               mbusy = nb;
            end
         end
      end
   end

   // Monitor: every cycle the write port must match the queue head due in that cycle, or stay idle.
   initial begin : monitor
      wr_t  w;
      logic exp_here;
      forever begin
         @(negedge clk);
         if (started) begin
            exp_here = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk1("rf_write_en", rf_write_en, exp_here);
            if (exp_here) begin
               w = exp_q.pop_front();
               if (rf_write_en === 1'b1) begin
                  chk32("rf_write_addr", 32'(rf_write_addr), 32'(w.addr));
                  chk32("rf_write_data", rf_write_data, w.data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      @(posedge clk);
      #1;
      started = 1'b1;
      chk1("reset_write_en", rf_write_en, 1'b0);
      chk32("reset_write_addr", 32'(rf_write_addr), 32'd0);
      chk32("reset_write_data", rf_write_data, 32'd0);
      chk1("reset_init_done", init_done, 1'b0);
      tick();
      reset = 1'b0;

      // Requesters and decode are active during INIT and must be ignored.
      wb0_valid = 1'b1; wb0_addr = 5'd2; wb0_data = 32'h0BAD_0002;
      wb1_valid = 1'b1; wb1_addr = 5'd3; wb1_data = 32'h0BAD_0003;
      issue_valid = 1'b1; issue_rd = 5'd6; rs1_addr = 5'd6; rs2_addr = 5'd3;
      repeat (30) tick();
      wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0;
      repeat (4) tick();

      wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD_BEEF;
      tick();
      wb0_valid = 1'b0;
      tick();

      wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h11;
      wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h22;
      repeat (3) tick();
      wb0_valid = 1'b0;
      tick();
      wb1_valid = 1'b0;
      tick();

      issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
      tick();
      issue_valid = 1'b0;
      tick();
      wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'hA5;
      tick();
      wb1_valid = 1'b0;
      repeat (2) tick();

      wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
      tick();
      wb0_valid = 1'b0; issue_valid = 1'b0;
      repeat (2) tick();

      // Reset in RUN with x9 busy and wb0 presenting a request.
      issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
      tick();
      issue_valid = 1'b0;
      wb0_valid = 1'b1; wb0_addr = 5'd12; wb0_data = 32'h1234_5678;
      reset = 1'b1;
      tick();
      reset = 1'b0; wb0_valid = 1'b0;
      repeat (36) tick();

      for (int i = 0; i < 1500; i++) begin
         if (!wb0_valid || acc0) begin
            wb0_valid = ($urandom_range(0, 9) < 6);
            wb0_addr  = 5'($urandom_range(0, 31));
            wb0_data  = $urandom;
         end
         if (!wb1_valid || acc1) begin
            wb1_valid = ($urandom_range(0, 9) < 6);
            wb1_addr  = 5'($urandom_range(0, 31));
            wb1_data  = $urandom;
         end
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_rd    = 5'($urandom_range(0, 31));
         rs1_addr    = 5'($urandom_range(0, 31));
         rs2_addr    = 5'($urandom_range(0, 31));
         reset       = (i == 700);
         tick();
      end
      reset = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0; issue_valid = 1'b0;
      repeat (3) tick();
      chk32("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
